// File: rtl/osc_sched_pkg.sv
// osc_sched_pkg
//   Shared definitions for the oscillator-clocked tick scheduler:
//   - cfg_state_e : configuration FSM states (IDLE, APPLY)
//   - OSC_*       : internal oscillator frequency constants
//   - prescale_for: oscillator cycles per base tick for a wanted base rate
package osc_sched_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } cfg_state_e;

    localparam int unsigned OSC_BASE_HZ  = 250_000_000;
    localparam int unsigned OSC_FREQ_DIV = 80;
    localparam int unsigned OSC_HZ       = OSC_BASE_HZ / OSC_FREQ_DIV;

    // Oscillator cycles per base tick for a base tick rate of hz.
    function automatic int unsigned prescale_for(input int unsigned hz);
        return OSC_HZ / hz;
    endfunction

endpackage

// File: rtl/osc_sched_channel.sv
// osc_sched_channel
//   One scheduler channel: divides the shared base tick by a programmable
//   period and produces a one-cycle tick strobe plus a square wave that
//   flips on every tick.
// Ports:
//   clk, rst_n        oscillator clock, asynchronous active-low reset
//   base_tick_i       one-cycle strobe from the shared prescaler
//   apply_i           configuration write to this channel (wins over counting)
//   apply_period_i    new period in base ticks (0 = stopped)
//   apply_en_i        new enable
//   tick_o            registered one-cycle tick strobe
//   toggle_o          registered square wave
module osc_sched_channel
    import osc_sched_pkg::*;
#(
    parameter int unsigned PER_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             base_tick_i,
    input  logic             apply_i,
    input  logic [PER_W-1:0] apply_period_i,
    input  logic             apply_en_i,
    output logic             tick_o,
    output logic             toggle_o
);

    logic [PER_W-1:0] period_q, period_d;
    logic             en_q, en_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             toggle_q, toggle_d;

    always_comb begin
        period_d = period_q;
        en_d     = en_q;
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        toggle_d = toggle_q;
        if (apply_i) begin
            // A write restarts the phase; a channel that ends up stopped
            // parks its square wave low, a running one keeps its level.
            period_d = apply_period_i;
            en_d     = apply_en_i;
            cnt_d    = '0;
            if (!apply_en_i || (apply_period_i == '0)) begin
                toggle_d = 1'b0;
            end
        end else if (base_tick_i && en_q && (period_q != '0)) begin
            // period_q is non-zero here, so period_q-1 cannot wrap.
            if (cnt_q == period_q - PER_W'(1)) begin
                cnt_d    = '0;
                tick_d   = 1'b1;
                toggle_d = ~toggle_q;
            end else begin
                cnt_d = cnt_q + PER_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
            en_q     <= 1'b0;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            period_q <= period_d;
            en_q     <= en_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            toggle_q <= toggle_d;
        end
    end

    assign tick_o   = tick_q;
    assign toggle_o = toggle_q;

endmodule

// File: rtl/osc_tick_scheduler.sv
// osc_tick_scheduler
//   Shared prescaler producing a base tick every PRESCALE oscillator cycles,
//   NUM_CH independent divider channels, and a two-state configuration FSM.
// Ports:
//   clk, rst_n      oscillator clock, asynchronous active-low reset
//   cfg_valid       configuration request
//   cfg_ready       configuration accept (registered)
//   cfg_ch          target channel; values >= NUM_CH are accepted and dropped
//   cfg_period      period in base ticks (0 = stopped)
//   cfg_en          channel enable
//   base_tick       one-cycle strobe every PRESCALE cycles
//   ch_tick         per-channel one-cycle tick strobe
//   ch_toggle       per-channel square wave (LED drive)
//   dbg_cfg_state   current configuration FSM state
//
// Handshake: a configuration transfer happens on a rising clk edge where
// cfg_valid && cfg_ready. cfg_valid may be held high; cfg_ch/cfg_period/cfg_en
// must be stable while cfg_valid is high and cfg_ready is low. cfg_ready
// drops for the single APPLY cycle after each transfer, so a held request
// is accepted every other cycle.
module osc_tick_scheduler
    import osc_sched_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned PRESCALE = prescale_for(1000),
    parameter int unsigned PER_W    = 16,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [PER_W-1:0]  cfg_period,
    input  logic              cfg_en,
    output logic              base_tick,
    output logic [NUM_CH-1:0] ch_tick,
    output logic [NUM_CH-1:0] ch_toggle,
    output cfg_state_e        dbg_cfg_state
);

    localparam int unsigned PC_W = $clog2(PRESCALE);

    // ---------------- prescaler ----------------
    logic [PC_W-1:0] pcnt_q, pcnt_d;
    logic            pcnt_last;
    logic            base_tick_q;

    assign pcnt_last = (pcnt_q == PC_W'(PRESCALE - 1));
    assign pcnt_d    = pcnt_last ? '0 : pcnt_q + PC_W'(1);

    // base_tick is high in the cycle following pcnt == PRESCALE-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q      <= '0;
            base_tick_q <= 1'b0;
        end else begin
            pcnt_q      <= pcnt_d;
            base_tick_q <= pcnt_last;
        end
    end

    assign base_tick = base_tick_q;

    // ---------------- configuration FSM ----------------
    cfg_state_e       state_q;
    logic             cfg_ready_q;
    logic [CH_W-1:0]  ch_q;
    logic [PER_W-1:0] period_q;
    logic             en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cfg_ready_q <= 1'b1;
            ch_q        <= '0;
            period_q    <= '0;
            en_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_valid && cfg_ready_q) begin
                        ch_q        <= cfg_ch;
                        period_q    <= cfg_period;
                        en_q        <= cfg_en;
                        state_q     <= APPLY;
                        cfg_ready_q <= 1'b0;
                    end
                end
                APPLY: begin
                    state_q     <= IDLE;
                    cfg_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    cfg_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cfg_ready     = cfg_ready_q;
    assign dbg_cfg_state = state_q;

    // ---------------- channels ----------------
    // An out-of-range latched channel matches no index, so the write is
    // silently dropped while the handshake still completes.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic apply_sel;
        assign apply_sel = (state_q == APPLY) && (ch_q == CH_W'(g));

        osc_sched_channel #(
            .PER_W (PER_W)
        ) u_ch (
            .clk            (clk),
            .rst_n          (rst_n),
            .base_tick_i    (base_tick_q),
            .apply_i        (apply_sel),
            .apply_period_i (period_q),
            .apply_en_i     (en_q),
            .tick_o         (ch_tick[g]),
            .toggle_o       (ch_toggle[g])
        );
    end

endmodule

// File: tb/tb_osc_tick_scheduler.sv
// tb_osc_tick_scheduler
//   Directed bench for osc_tick_scheduler with PRESCALE=4, NUM_CH=4, PER_W=8.
//   Expected channel ticks are pushed when a write is issued; a negedge
//   monitor pops and compares them whenever ch_tick is seen.
module tb_osc_tick_scheduler;
  import osc_sched_pkg::*;

  localparam int NUM_CH   = 4;
  localparam int PRESCALE = 4;
  localparam int PER_W    = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [PER_W-1:0]  cfg_period;
  logic              cfg_en;
  logic              base_tick;
  logic [NUM_CH-1:0] ch_tick;
  logic [NUM_CH-1:0] ch_toggle;
  cfg_state_e        dbg_state;

  osc_tick_scheduler #(
    .NUM_CH   (NUM_CH),
    .PRESCALE (PRESCALE),
    .PER_W    (PER_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_ch        (cfg_ch),
    .cfg_period    (cfg_period),
    .cfg_en        (cfg_en),
    .base_tick     (base_tick),
    .ch_tick       (ch_tick),
    .ch_toggle     (ch_toggle),
    .dbg_cfg_state (dbg_state)
  );

  // Rising edges since reset release.
  int cyc = 0;
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- checking helpers ----------------
  int pass_cnt  = 0;
  int check_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: cyc=%0d got 0x%0h expected 0x%0h", name, cyc, act, exp);
  endtask

  task automatic fail(input string name, input int act, input int exp);
    check_cnt++;
    $display("FAIL %s: cyc=%0d got %0d expected %0d", name, cyc, act, exp);
  endtask

  // ---------------- scoreboard ----------------
  // Entry: [23:8] cycle of the tick, [7:4] channel, [0] toggle level after it.
  logic [23:0] exp_q[$];

  task automatic exp_tick(input int c, input int ch, input bit tg);
    logic [23:0] e;
    int i;
    e = {c[15:0], 4'(ch), 3'b000, tg};
    i = 0;
    while (i < exp_q.size() && exp_q[i][23:4] <= e[23:4]) i++;
    exp_q.insert(i, e);
  endtask

  logic [23:0] mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      check("base_tick", 32'(base_tick), 32'(cyc >= PRESCALE && cyc % PRESCALE == 0));
      while (exp_q.size() > 0 && int'(exp_q[0][23:8]) < cyc) begin
        mon_e = exp_q.pop_front();
        fail("tick_missing", 0, int'(mon_e[23:8]));
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (ch_tick[ch]) begin
          if (exp_q.size() == 0) begin
            fail("tick_unexpected", ch, -1);
          end else begin
            mon_e = exp_q.pop_front();
            check("tick_cycle", 32'(cyc), 32'(mon_e[23:8]));
            check("tick_channel", 32'(ch), 32'(mon_e[7:4]));
            check("tick_toggle", 32'(ch_toggle[ch]), 32'(mon_e[0]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_neg(input int n);
    int k;
    k = 0;
    while (cyc != n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (cyc != n) fail("wait_timeout", cyc, n);
  endtask

  // Transfer lands on rising edge 'at'; the channel is written on edge at+1.
  task automatic cfg_write(input int at, input int ch, input int per, input bit en);
    wait_neg(at - 1);
    check("ready_before_write", 32'(cfg_ready), 32'd1);
    cfg_valid  = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_period = PER_W'(per);
    cfg_en     = en;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("ready_in_apply", 32'(cfg_ready), 32'd0);
    check("state_apply", 32'(dbg_state), 32'(APPLY));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_period = '0;
    cfg_en     = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_base_tick", 32'(base_tick), 32'd0);
    check("rst_ch_tick", 32'(ch_tick), 32'd0);
    check("rst_ch_toggle", 32'(ch_toggle), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;

    // ch0 period 3: applied at edge 3, base-tick updates at edges 5,9,13,...
    cfg_write(2, 0, 3, 1'b1);
    exp_tick(13, 0, 1'b1);
    exp_tick(25, 0, 1'b0);
    exp_tick(37, 0, 1'b1);

    // ch1 enabled with period 0: must stay silent.
    cfg_write(6, 1, 0, 1'b1);

    // ch3 period 2: applied at edge 11.
    cfg_write(10, 3, 2, 1'b1);
    exp_tick(17, 3, 1'b1);
    exp_tick(25, 3, 1'b0);
    exp_tick(33, 3, 1'b1);
    exp_tick(41, 3, 1'b0);

    // ch2 period 2: applied at edge 15, ticks at 21.
    cfg_write(14, 2, 2, 1'b1);
    exp_tick(21, 2, 1'b1);

    // Rewrite ch2 on edge 29, its terminal update: no tick there, next at 37,
    // toggle level kept across the rewrite.
    cfg_write(28, 2, 2, 1'b1);
    exp_tick(37, 2, 1'b0);

    // Disable ch0 mid-count: toggle falls on the APPLY edge (41).
    cfg_write(40, 0, 3, 1'b0);
    check("toggle0_before_stop", 32'(ch_toggle[0]), 32'd1);
    @(negedge clk);
    check("toggle0_after_stop", 32'(ch_toggle[0]), 32'd0);

    // Back-to-back writes with cfg_valid held: disable ch2, then ch3.
    wait_neg(43);
    check("b2b_ready_0", 32'(cfg_ready), 32'd1);
    cfg_valid  = 1'b1;
    cfg_ch     = 2'd2;
    cfg_period = '0;
    cfg_en     = 1'b0;
    @(negedge clk);
    check("b2b_ready_1", 32'(cfg_ready), 32'd0);
    cfg_ch     = 2'd3;
    cfg_period = PER_W'(2);
    cfg_en     = 1'b0;
    @(negedge clk);
    check("b2b_ready_2", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    check("b2b_ready_3", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    @(negedge clk);
    check("b2b_ready_4", 32'(cfg_ready), 32'd1);

    // Period 1 ticks on every base tick.
    cfg_write(50, 0, 1, 1'b1);
    exp_tick(53, 0, 1'b1);
    exp_tick(57, 0, 1'b0);
    exp_tick(61, 0, 1'b1);
    cfg_write(54, 1, 1, 1'b1);
    exp_tick(57, 1, 1'b1);
    exp_tick(61, 1, 1'b0);

    wait_neg(62);
    check("queue_drained_1", 32'(exp_q.size()), 32'd0);
    check("toggle_before_reset", 32'(ch_toggle), 32'b0001);

    // Asynchronous reset between edges.
    #1 rst_n = 1'b0;
    #1;
    check("async_ch_toggle", 32'(ch_toggle), 32'd0);
    check("async_ch_tick", 32'(ch_tick), 32'd0);
    check("async_base_tick", 32'(base_tick), 32'd0);
    check("async_cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Only the new ch2 write may produce ticks; old configuration is gone.
    cfg_write(2, 2, 2, 1'b1);
    exp_tick(9, 2, 1'b1);
    exp_tick(17, 2, 1'b0);

    wait_neg(24);
    check("queue_drained_2", 32'(exp_q.size()), 32'd0);
    check("toggle_after_reset", 32'(ch_toggle), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
